coh_bus_nc: RTL and testbench
=============================

Name: coh_bus_nc

Overview:
- Parametrised N-core pipelined snooping coherence bus.
- Arbitrates atomic requests from NUM_CORES L1 data caches with a rotating round-robin arbiter.
- Broadcasts the winning request to all caches and to the data memory controller.
- Tracks data-returning transactions in a DEPTH-entry in-order response queue; data is filled by a snooping core or by the memory controller, and responses return to the requester in order.

Parameters:
- NUM_CORES, 4, number of requesting caches (>=2).
- RSPQ_DEPTH, 4, response queue entries (power of 2, >=2).
- TAG_W, 51, cache tag width.
- IDX_W, 10, cache index width.
- DATA_W, 64, data word width.
- Derived: ID_W = clog2(NUM_CORES); PTR_W = clog2(RSPQ_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_en_i  in  NUM_CORES  per-core request valid.
- req_tag_i  in  NUM_CORES*TAG_W  per-core tag; core k in slice k.
- req_idx_i  in  NUM_CORES*IDX_W  per-core index.
- req_data_i  in  NUM_CORES*DATA_W  per-core writeback data.
- req_msg_i  in  NUM_CORES x message_t  per-core message (GET_S, GET_M, PUT_M, NONE).
- snp_rsp_vld_i  in  NUM_CORES  core supplies data for the current bus request.
- snp_rsp_data_i  in  NUM_CORES*DATA_W  snoop data.
- rsp_ack_i  in  NUM_CORES  requester consumed the head response.
- req_ack_o  out  NUM_CORES  one-hot; request accepted this cycle.
- mem_rsp_ack_i  in  1  memory controller accepted the bus request.
- mem_rsp_vld_i  in  1  memory data valid.
- mem_rsp_ptr_i  in  PTR_W  queue entry that the memory data fills.
- mem_rsp_data_i  in  DATA_W  memory data.
- mem_rsp_ptr_o  out  PTR_W  current tail pointer, tagging the issued request.
- bus_req_id_o  out  ID_W  granted core.
- bus_req_tag_o  out  TAG_W  broadcast tag.
- bus_req_idx_o  out  IDX_W  broadcast index.
- bus_req_msg_o  out  message_t  broadcast message; NONE when idle.
- bus_req_data_o  out  DATA_W  broadcast data.
- bus_rsp_vld_o  out  1  head entry has data.
- bus_rsp_id_o  out  ID_W  head requester.
- bus_rsp_data_o  out  DATA_W  head data.
- bus_rsp_addr_o  out  64  {tag, idx, 3'b0} of head.
- rspq_cnt_o  out  PTR_W+1  occupied entries.
- proto_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release): all queue fields, pointers, wrap bits, rr_ptr, cnt and proto_err go to 0. Outputs: bus_req_msg_o=NONE, tag/idx/data/id = 0, bus_rsp_vld_o=0, req_ack_o=0.
- Eligibility: core k is eligible if req_en_i[k] and no valid queue entry matches its {tag,idx} (pending hit). A pending hit blocks only that core.
- Arbitration (combinational): grant the first eligible core searching from rr_ptr upward with wrap. Bus outputs carry the granted core's fields; with no grant, all zero and msg = NONE.
- Acceptance: accept = grant & ~stall & (|snp_rsp_vld_i | mem_rsp_ack_i). stall = full & ~pop. req_ack_o[grant] = accept.
- rr_ptr advances to (granted+1) mod NUM_CORES only on accept; otherwise it holds. A stalled core keeps its grant.
- Allocation: on accept with msg GET_S or GET_M, write tag, idx, id and vld=1 at tail; tail increments with wrap bit toggling at RSPQ_DEPTH-1. PUT_M accept allocates nothing.
- Snoop fill: in the accept cycle, if any snp_rsp_vld_i is set, tail data = the lowest-index asserting core's data and rdy=1. More than one asserting sets proto_err.
- Memory fill: mem_rsp_vld_i writes data and rdy=1 at mem_rsp_ptr_i. Memory fill to an entry with vld=0, or with rdy already 1, is dropped and sets proto_err.
- Response: bus_rsp_* driven from head. pop = rsp_ack_i[bus_rsp_id_o] & bus_rsp_vld_o. pop clears the head entry and increments head. An ack from a non-head requester, or an ack while rdy=0, is ignored and sets proto_err.
- Full / empty: full = wrap bits differ and pointers are equal; empty = both equal. When full, alloc and pop in the same cycle are allowed.
- Field precedence within a cycle (lowest to highest): pop clear, memory fill, snoop fill, allocation.
- rspq_cnt_o = tail - head including the wrap bit; +1 on alloc, -1 on pop, unchanged on both.
- Latency: minimum request-to-response is 1 cycle (snoop fill in the accept cycle, rsp_vld the next cycle).
- proto_err clears only on reset.

Test Plan:
- Round-robin: cores 0-3 all request GET_S (distinct addresses), snp_rsp_vld_i[1]=1 each cycle → acks go 0,1,2,3 on consecutive cycles; rspq_cnt_o reaches 4; further requests stall.
- Pending hit: core2 GET_S to tag 0x5, idx 0x3 accepted, then core0 requests the same address → core0 blocked while core1 (different address) is acked; core0 is acked after the entry pops.
- Memory fill out of order: allocate entries 0 and 1 via mem_rsp_ack_i, fill ptr1 data 0xBEEF, then ptr0 data 0xCAFE → bus_rsp_data_o shows 0xCAFE first, then 0xBEEF after the pop.
- Full with simultaneous pop: queue of 4 is full, head ready, requester acks the same cycle as a new GET_M with a snoop → accepted; cnt stays 4; tail wraps to 1 with its wrap bit toggled.
- PUT_M: core3 PUT_M data 0x1234 with mem_rsp_ack_i → req_ack_o=4'b1000, bus_req_data_o=0x1234, cnt unchanged.
- Errors and reset: memory fill to an invalid entry → proto_err_o=1 and held; asserting rst_n=0 mid-transaction immediately clears the queue, cnt and flag.

Source files
------------

// File: rtl/coh_bus_nc.sv
// coh_bus_nc: N-core pipelined snooping coherence bus.
//
// Each cycle one requesting L1 is chosen by a rotating round-robin arbiter and
// its request is broadcast to all caches and to the memory controller. Requests
// that return data (GET_S / GET_M) take an entry in an in-order response queue.
// That entry is filled either by a snooping core in the accept cycle or later
// by the memory controller, which may fill entries out of order. Responses
// leave the queue strictly in order.
//
// Message encoding (2 bits per core): 0 NONE, 1 GET_S, 2 GET_M, 3 PUT_M.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_en/tag/idx/data/msg_i      per-core request, core k in slice k
//   snp_rsp_vld_i, snp_rsp_data_i  snoop data for the request on the bus
//   rsp_ack_i                      requester consumed the head response
//   req_ack_o                      one-hot request accept
//   mem_rsp_ack_i                  memory controller accepted the bus request
//   mem_rsp_vld/ptr/data_i         memory fill of queue entry ptr
//   mem_rsp_ptr_o                  queue tail tagging the issued request
//   bus_req_*_o                    broadcast request, msg NONE when idle
//   bus_rsp_*_o                    head response, addr = {tag, idx, 3'b0}
//   rspq_cnt_o                     occupied queue entries
//   proto_err_o                    sticky protocol error
module coh_bus_nc #(
   parameter int NUM_CORES  = 4,
   parameter int RSPQ_DEPTH = 4,
   parameter int TAG_W      = 51,
   parameter int IDX_W      = 10,
   parameter int DATA_W     = 64,
   localparam int ID_W      = $clog2(NUM_CORES),
   localparam int PTR_W     = $clog2(RSPQ_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CORES-1:0]      req_en_i,
   input  logic [NUM_CORES*TAG_W-1:0]  req_tag_i,
   input  logic [NUM_CORES*IDX_W-1:0]  req_idx_i,
   input  logic [NUM_CORES*DATA_W-1:0] req_data_i,
   input  logic [NUM_CORES*2-1:0]      req_msg_i,
   input  logic [NUM_CORES-1:0]      snp_rsp_vld_i,
   input  logic [NUM_CORES*DATA_W-1:0] snp_rsp_data_i,
   input  logic [NUM_CORES-1:0]      rsp_ack_i,
   output logic [NUM_CORES-1:0]      req_ack_o,
   input  logic                      mem_rsp_ack_i,
   input  logic                      mem_rsp_vld_i,
   input  logic [PTR_W-1:0]          mem_rsp_ptr_i,
   input  logic [DATA_W-1:0]         mem_rsp_data_i,
   output logic [PTR_W-1:0]          mem_rsp_ptr_o,
   output logic [ID_W-1:0]           bus_req_id_o,
   output logic [TAG_W-1:0]          bus_req_tag_o,
   output logic [IDX_W-1:0]          bus_req_idx_o,
   output logic [1:0]                bus_req_msg_o,
   output logic [DATA_W-1:0]         bus_req_data_o,
   output logic                      bus_rsp_vld_o,
   output logic [ID_W-1:0]           bus_rsp_id_o,
   output logic [DATA_W-1:0]         bus_rsp_data_o,
   output logic [63:0]               bus_rsp_addr_o,
   output logic [PTR_W:0]            rspq_cnt_o,
   output logic                      proto_err_o
);

   localparam logic [1:0] MSG_NONE  = 2'd0;
   localparam logic [1:0] MSG_GET_S = 2'd1;
   localparam logic [1:0] MSG_GET_M = 2'd2;
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
      return ID_W'((int'(base) + off) % NUM_CORES);
   endfunction

   logic              q_vld  [RSPQ_DEPTH];
   logic              q_rdy  [RSPQ_DEPTH];
   logic [TAG_W-1:0]  q_tag  [RSPQ_DEPTH];
   logic [IDX_W-1:0]  q_idx  [RSPQ_DEPTH];
   logic [ID_W-1:0]   q_id   [RSPQ_DEPTH];
   logic [DATA_W-1:0] q_data [RSPQ_DEPTH];

   // Pointers carry the wrap bit in their MSB.
   logic [PTR_W:0]    head_f, tail_f;
   logic [PTR_W-1:0]  head, tail;
   logic [ID_W-1:0]   rr_ptr;
   logic              proto_err;

   logic [TAG_W-1:0]  tag_k  [NUM_CORES];
   logic [IDX_W-1:0]  idx_k  [NUM_CORES];
   logic [DATA_W-1:0] data_k [NUM_CORES];
   logic [1:0]        msg_k  [NUM_CORES];
   logic [NUM_CORES-1:0] pend_hit, elig, head_onehot;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_id;
   logic [DATA_W-1:0] snp_sel;
   logic              snp_any, snp_multi, full, pop, stall, accept, alloc;
   logic              mem_ok, mem_err, ack_err;

   always_comb begin
      for (int k = 0; k < NUM_CORES; k++) begin
         tag_k[k]  = req_tag_i[k*TAG_W +: TAG_W];
         idx_k[k]  = req_idx_i[k*IDX_W +: IDX_W];
         data_k[k] = req_data_i[k*DATA_W +: DATA_W];
         msg_k[k]  = req_msg_i[k*2 +: 2];
      end
   end

   // A core whose line already has an outstanding entry waits until it pops.
   always_comb begin
      pend_hit = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         for (int e = 0; e < RSPQ_DEPTH; e++) begin
            if (q_vld[e] && q_tag[e] == tag_k[k] && q_idx[e] == idx_k[k]) begin
               pend_hit[k] = 1'b1;
            end
         end
      end
      elig = req_en_i & ~pend_hit;
   end

   // Scan downwards so the core closest to rr_ptr is written last and wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (elig[rr_idx(rr_ptr, i)]) begin
            grant_vld = 1'b1;
            grant_id  = rr_idx(rr_ptr, i);
         end
      end
   end

   always_comb begin
      snp_sel = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (snp_rsp_vld_i[i]) snp_sel = snp_rsp_data_i[i*DATA_W +: DATA_W];
      end
   end

   assign snp_any   = |snp_rsp_vld_i;
   assign snp_multi = |(snp_rsp_vld_i & (snp_rsp_vld_i - NUM_CORES'(1)));

   assign head = head_f[PTR_W-1:0];
   assign tail = tail_f[PTR_W-1:0];
   assign full = (head == tail) && (head_f[PTR_W] != tail_f[PTR_W]);

   assign bus_rsp_vld_o  = q_vld[head] & q_rdy[head];
   assign bus_rsp_id_o   = q_id[head];
   assign bus_rsp_data_o = q_data[head];
   assign bus_rsp_addr_o = 64'({q_tag[head], q_idx[head], 3'b000});

   assign pop         = bus_rsp_vld_o & rsp_ack_i[bus_rsp_id_o];
   assign head_onehot = bus_rsp_vld_o ? (NUM_CORES'(1) << bus_rsp_id_o) : '0;
   assign ack_err     = |(rsp_ack_i & ~head_onehot);

   assign mem_ok  = q_vld[mem_rsp_ptr_i] & ~q_rdy[mem_rsp_ptr_i];
   assign mem_err = mem_rsp_vld_i & ~mem_ok;

   // A pop frees the tail slot of a full queue in the same cycle.
   assign stall  = full & ~pop;
   assign accept = grant_vld & ~stall & (snp_any | mem_rsp_ack_i);
   assign alloc  = accept & (msg_k[grant_id] == MSG_GET_S || msg_k[grant_id] == MSG_GET_M);

   assign req_ack_o      = accept ? (NUM_CORES'(1) << grant_id) : '0;
   assign bus_req_id_o   = grant_vld ? grant_id : '0;
   assign bus_req_tag_o  = grant_vld ? tag_k[grant_id] : '0;
   assign bus_req_idx_o  = grant_vld ? idx_k[grant_id] : '0;
   assign bus_req_msg_o  = grant_vld ? msg_k[grant_id] : MSG_NONE;
   assign bus_req_data_o = grant_vld ? data_k[grant_id] : '0;

   assign mem_rsp_ptr_o = tail;
   assign rspq_cnt_o    = tail_f - head_f;
   assign proto_err_o   = proto_err;

   // Later writes override earlier ones: pop clear < memory fill < snoop fill / allocation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_f    <= '0;
         tail_f    <= '0;
         rr_ptr    <= '0;
         proto_err <= 1'b0;
         for (int e = 0; e < RSPQ_DEPTH; e++) begin
            q_vld[e]  <= 1'b0;
            q_rdy[e]  <= 1'b0;
            q_tag[e]  <= '0;
            q_idx[e]  <= '0;
            q_id[e]   <= '0;
            q_data[e] <= '0;
         end
      end else begin
         if (pop) begin
            q_vld[head]  <= 1'b0;
            q_rdy[head]  <= 1'b0;
            q_tag[head]  <= '0;
            q_idx[head]  <= '0;
            q_id[head]   <= '0;
            q_data[head] <= '0;
            head_f       <= head_f + PTR_ONE;
         end
         if (mem_rsp_vld_i && mem_ok) begin
            q_data[mem_rsp_ptr_i] <= mem_rsp_data_i;
            q_rdy[mem_rsp_ptr_i]  <= 1'b1;
         end
         if (alloc) begin
            q_vld[tail] <= 1'b1;
            q_rdy[tail] <= snp_any;
            q_tag[tail] <= tag_k[grant_id];
            q_idx[tail] <= idx_k[grant_id];
            q_id[tail]  <= grant_id;
            if (snp_any) q_data[tail] <= snp_sel;
            tail_f      <= tail_f + PTR_ONE;
         end
         if (accept) rr_ptr <= rr_idx(grant_id, 1);
         if ((accept && snp_multi) || mem_err || ack_err) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_coh_bus_nc.sv
// Bench for coh_bus_nc: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-level reference model of the bus.
module tb_coh_bus_nc;

   localparam int NC = 4, D = 4, TW = 51, IW = 10, DW = 64;
   localparam logic [1:0] M_NONE = 2'd0, M_GETS = 2'd1, M_GETM = 2'd2, M_PUTM = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NC-1:0] req_en, snp_vld, rsp_ack, req_ack;
   logic [TW-1:0] c_tag  [NC];
   logic [IW-1:0] c_idx  [NC];
   logic [DW-1:0] c_data [NC];
   logic [DW-1:0] c_snp  [NC];
   logic [1:0]    c_msg  [NC];
   logic [NC*TW-1:0] tag_f;
   logic [NC*IW-1:0] idx_f;
   logic [NC*DW-1:0] data_f, snp_f;
   logic [NC*2-1:0]  msg_f;
   logic          mem_ack, mem_vld;
   logic [1:0]    mem_ptr;
   logic [DW-1:0] mem_data;

   logic [1:0]    mem_rsp_ptr_o, bus_req_id_o, bus_req_msg_o, bus_rsp_id_o;
   logic [TW-1:0] bus_req_tag_o;
   logic [IW-1:0] bus_req_idx_o;
   logic [DW-1:0] bus_req_data_o, bus_rsp_data_o;
   logic          bus_rsp_vld_o, proto_err_o;
   logic [63:0]   bus_rsp_addr_o;
   logic [2:0]    rspq_cnt_o;

   for (genvar k = 0; k < NC; k++) begin : g_pack
      assign tag_f[k*TW +: TW]  = c_tag[k];
      assign idx_f[k*IW +: IW]  = c_idx[k];
      assign data_f[k*DW +: DW] = c_data[k];
      assign snp_f[k*DW +: DW]  = c_snp[k];
      assign msg_f[k*2 +: 2]    = c_msg[k];
   end

   coh_bus_nc dut (
      .clk(clk), .rst_n(rst_n),
      .req_en_i(req_en), .req_tag_i(tag_f), .req_idx_i(idx_f),
      .req_data_i(data_f), .req_msg_i(msg_f),
      .snp_rsp_vld_i(snp_vld), .snp_rsp_data_i(snp_f),
      .rsp_ack_i(rsp_ack), .req_ack_o(req_ack),
      .mem_rsp_ack_i(mem_ack), .mem_rsp_vld_i(mem_vld),
      .mem_rsp_ptr_i(mem_ptr), .mem_rsp_data_i(mem_data),
      .mem_rsp_ptr_o(mem_rsp_ptr_o),
      .bus_req_id_o(bus_req_id_o), .bus_req_tag_o(bus_req_tag_o),
      .bus_req_idx_o(bus_req_idx_o), .bus_req_msg_o(bus_req_msg_o),
      .bus_req_data_o(bus_req_data_o),
      .bus_rsp_vld_o(bus_rsp_vld_o), .bus_rsp_id_o(bus_rsp_id_o),
      .bus_rsp_data_o(bus_rsp_data_o), .bus_rsp_addr_o(bus_rsp_addr_o),
      .rspq_cnt_o(rspq_cnt_o), .proto_err_o(proto_err_o)
   );

   // Reference model: D slots used as a circular list of outstanding
   // transactions, described by oldest slot and a count.
   typedef struct {
      bit            vld;
      bit            rdy;
      logic [TW-1:0] tag;
      logic [IW-1:0] idx;
      int            id;
      logic [DW-1:0] data;
   } ent_t;

   ent_t mq [D];
   int   m_head, m_cnt, m_rr;
   bit   m_err;

   int n_cmp = 0, n_bad = 0;
   logic [NC-1:0] obs_ack;
   logic [DW-1:0] obs_rsp_data, obs_req_data;
   logic [63:0]   obs_cnt, obs_ptr, obs_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < D; s++) begin
         mq[s].vld = 0; mq[s].rdy = 0; mq[s].tag = '0;
         mq[s].idx = '0; mq[s].id = 0; mq[s].data = '0;
      end
      m_head = 0; m_cnt = 0; m_rr = 0; m_err = 0;
   endtask

   task automatic idle();
      req_en = '0; snp_vld = '0; rsp_ack = '0;
      mem_ack = 0; mem_vld = 0; mem_ptr = '0; mem_data = '0;
      for (int k = 0; k < NC; k++) begin
         c_tag[k] = '0; c_idx[k] = '0; c_data[k] = '0; c_snp[k] = '0; c_msg[k] = M_NONE;
      end
   endtask

   task automatic req(input int k, input logic [1:0] msg, input logic [TW-1:0] tag,
                      input logic [IW-1:0] idx, input logic [DW-1:0] data);
      req_en[k] = 1'b1; c_msg[k] = msg; c_tag[k] = tag; c_idx[k] = idx; c_data[k] = data;
   endtask

   // One clock: sample DUT mid-cycle, compare with the model, advance the model.
   task automatic cycle();
      logic [NC-1:0] elig, exp_ack;
      int g, tl, nsnp;
      bit rvld, pop, full, acc, fill_ok;
      ent_t hd;
      logic [DW-1:0] sd;
      logic [63:0] e_id, e_tag, e_idx, e_msg, e_data;
      @(negedge clk); #1;
      for (int k = 0; k < NC; k++) begin
         bit hit;
         hit = 0;
         for (int s = 0; s < D; s++)
            if (mq[s].vld && mq[s].tag == c_tag[k] && mq[s].idx == c_idx[k]) hit = 1;
         elig[k] = req_en[k] && !hit;
      end
      g = -1;
      for (int i = 0; i < NC; i++) begin
         int c;
         c = (m_rr + i) % NC;
         if (g < 0 && elig[c]) g = c;
      end
      hd   = mq[m_head];
      rvld = hd.vld && hd.rdy;
      pop  = rvld && rsp_ack[hd.id];
      full = (m_cnt == D);
      tl   = (m_head + m_cnt) % D;
      nsnp = $countones(snp_vld);
      sd   = '0;
      for (int k = NC-1; k >= 0; k--) if (snp_vld[k]) sd = c_snp[k];
      acc  = (g >= 0) && !(full && !pop) && (nsnp > 0 || mem_ack);
      exp_ack = acc ? (NC'(1) << g) : '0;
      if (g >= 0) begin
         e_id = 64'(g); e_tag = 64'(c_tag[g]); e_idx = 64'(c_idx[g]);
         e_msg = 64'(c_msg[g]); e_data = 64'(c_data[g]);
      end else begin
         e_id = 0; e_tag = 0; e_idx = 0; e_msg = 64'(M_NONE); e_data = 0;
      end

      obs_ack = req_ack; obs_rsp_data = bus_rsp_data_o; obs_req_data = bus_req_data_o;
      obs_cnt = 64'(rspq_cnt_o); obs_ptr = 64'(mem_rsp_ptr_o); obs_err = 64'(proto_err_o);

      chk("req_ack",  64'(req_ack), 64'(exp_ack));
      chk("req_id",   64'(bus_req_id_o), e_id);
      chk("req_tag",  64'(bus_req_tag_o), e_tag);
      chk("req_idx",  64'(bus_req_idx_o), e_idx);
      chk("req_msg",  64'(bus_req_msg_o), e_msg);
      chk("req_data", 64'(bus_req_data_o), e_data);
      chk("rsp_vld",  64'(bus_rsp_vld_o), 64'(rvld));
      if (rvld) begin
         chk("rsp_id",   64'(bus_rsp_id_o), 64'(hd.id));
         chk("rsp_data", 64'(bus_rsp_data_o), 64'(hd.data));
         chk("rsp_addr", bus_rsp_addr_o, (64'(hd.tag) << 13) | (64'(hd.idx) << 3));
      end
      chk("rspq_cnt", 64'(rspq_cnt_o), 64'(m_cnt));
      chk("mem_ptr",  64'(mem_rsp_ptr_o), 64'(tl));
      chk("proto_err", 64'(proto_err_o), 64'(m_err));

      fill_ok = mq[mem_ptr].vld && !mq[mem_ptr].rdy;
      if (acc && nsnp > 1) m_err = 1;
      if (mem_vld && !fill_ok) m_err = 1;
      for (int k = 0; k < NC; k++)
         if (rsp_ack[k] && !(rvld && k == hd.id)) m_err = 1;
      if (pop) begin
         mq[m_head].vld = 0; mq[m_head].rdy = 0; mq[m_head].tag = '0;
         mq[m_head].idx = '0; mq[m_head].id = 0; mq[m_head].data = '0;
         m_head = (m_head + 1) % D;
         m_cnt--;
      end
      if (mem_vld && fill_ok) begin
         mq[mem_ptr].data = mem_data;
         mq[mem_ptr].rdy = 1;
      end
      if (acc && (c_msg[g] == M_GETS || c_msg[g] == M_GETM)) begin
         mq[tl].vld = 1; mq[tl].rdy = (nsnp > 0);
         mq[tl].tag = c_tag[g]; mq[tl].idx = c_idx[g]; mq[tl].id = g;
         mq[tl].data = (nsnp > 0) ? sd : '0;
         m_cnt++;
      end
      if (acc) m_rr = (g + 1) % NC;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int budget;
      budget = 40;
      while (m_cnt > 0 && budget > 0) begin
         idle();
         if (mq[m_head].rdy) rsp_ack[mq[m_head].id] = 1'b1;
         else begin
            mem_vld = 1'b1; mem_ptr = 2'(m_head); mem_data = {$urandom, $urandom};
         end
         cycle();
         budget--;
      end
      idle();
      chk("drain_empty", 64'(rspq_cnt_o), 64'd0);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, slot_a;
      int cand[$];
      idle();
      do_reset();

      // reset state
      cycle();
      chk("rst_ack", 64'(obs_ack), 64'd0);
      chk("rst_cnt", obs_cnt, 64'd0);
      chk("rst_err", obs_err, 64'd0);

      // round robin with a snooper supplying data every cycle
      for (int k = 0; k < NC; k++) req(k, M_GETS, TW'(64'h100 + k), IW'(k), 64'(k));
      snp_vld = 4'b0010; c_snp[1] = 64'hD00D;
      for (int i = 0; i < NC; i++) begin
         cycle();
         chk($sformatf("rr_ack%0d", i), 64'(obs_ack), 64'(4'b0001 << i));
      end
      c_tag[0] = TW'(64'h200);
      cycle();
      chk("rr_stall_ack", 64'(obs_ack), 64'd0);
      chk("rr_cnt4", obs_cnt, 64'd4);
      drain();

      // pending hit blocks only the hitting core
      idle();
      slot_a = (m_head + m_cnt) % D;
      req(2, M_GETS, TW'(5), IW'(3), 64'h0);
      mem_ack = 1;
      cycle();
      chk("ph_ack2", 64'(obs_ack), 64'(4'b0100));
      req_en[2] = 0;
      req(0, M_GETS, TW'(5), IW'(3), 64'h0);
      req(1, M_GETS, TW'(7), IW'(1), 64'h0);
      cycle();
      chk("ph_ack1", 64'(obs_ack), 64'(4'b0010));
      req_en[1] = 0; mem_ack = 0;
      cycle();
      chk("ph_blk0", 64'(obs_ack), 64'd0);
      mem_ack = 1; mem_vld = 1; mem_ptr = 2'(slot_a); mem_data = 64'h55;
      cycle();
      chk("ph_blk0_fill", 64'(obs_ack), 64'd0);
      mem_vld = 0; rsp_ack = 4'b0100;
      cycle();
      chk("ph_blk0_pop", 64'(obs_ack), 64'd0);
      rsp_ack = '0;
      cycle();
      chk("ph_ack0", 64'(obs_ack), 64'(4'b0001));
      drain();

      // out-of-order memory fill, in-order response
      idle();
      t0 = (m_head + m_cnt) % D;
      req(0, M_GETS, TW'(64'h10), IW'(16), 64'h0);
      mem_ack = 1;
      cycle();
      req_en[0] = 0;
      t1 = (m_head + m_cnt) % D;
      req(1, M_GETS, TW'(64'h11), IW'(17), 64'h0);
      cycle();
      idle();
      mem_vld = 1; mem_ptr = 2'(t1); mem_data = 64'hBEEF;
      cycle();
      mem_ptr = 2'(t0); mem_data = 64'hCAFE;
      cycle();
      mem_vld = 0; rsp_ack = 4'b0001;
      cycle();
      chk("ooo_first", 64'(obs_rsp_data), 64'hCAFE);
      rsp_ack = 4'b0010;
      cycle();
      chk("ooo_second", 64'(obs_rsp_data), 64'hBEEF);
      drain();

      // full queue accepts a new request when the head pops the same cycle
      do_reset();
      for (int k = 0; k < NC; k++) req(k, M_GETS, TW'(64'h300 + k), IW'(k), 64'h0);
      snp_vld = 4'b0001; c_snp[0] = 64'hA5A5_0000_1111_2222;
      repeat (NC) cycle();
      c_msg[0] = M_GETM; c_tag[0] = TW'(64'h400);
      rsp_ack = 4'b0001;
      cycle();
      chk("full_pop_ack", 64'(obs_ack), 64'(4'b0001));
      chk("full_pop_cnt_pre", obs_cnt, 64'd4);
      idle();
      cycle();
      chk("full_pop_cnt", obs_cnt, 64'd4);
      chk("full_pop_tail", obs_ptr, 64'd1);
      drain();

      // PUT_M is acknowledged but allocates nothing
      idle();
      req(3, M_PUTM, TW'(64'h77), IW'(7), 64'h1234);
      mem_ack = 1;
      cycle();
      chk("putm_ack", 64'(obs_ack), 64'(4'b1000));
      chk("putm_data", 64'(obs_req_data), 64'h1234);
      idle();
      cycle();
      chk("putm_cnt", obs_cnt, 64'd0);

      // protocol errors
      do_reset();
      rsp_ack = 4'b0001;
      cycle();
      idle();
      cycle();
      chk("err_ack", obs_err, 64'd1);

      do_reset();
      req(0, M_GETS, TW'(64'h9), IW'(9), 64'h0);
      snp_vld = 4'b0110; c_snp[1] = 64'h1111; c_snp[2] = 64'h2222;
      cycle();
      idle();
      cycle();
      chk("err_snp", obs_err, 64'd1);
      chk("snp_lowest", 64'(obs_rsp_data), 64'h1111);

      do_reset();
      mem_vld = 1; mem_ptr = 2'd2; mem_data = 64'h77;
      cycle();
      idle();
      repeat (3) cycle();
      chk("err_held", obs_err, 64'd1);
      req(1, M_GETS, TW'(64'h33), IW'(3), 64'h0);
      mem_ack = 1;
      cycle();
      idle();
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt", 64'(rspq_cnt_o), 64'd0);
      chk("arst_err", 64'(proto_err_o), 64'd0);
      chk("arst_rsp_vld", 64'(bus_rsp_vld_o), 64'd0);
      model_clear();
      @(posedge clk); #1 rst_n = 1'b1;
      cycle();

      // randomized legal traffic; no protocol errors expected
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < NC; k++) begin
            req_en[k] = ($urandom_range(0, 9) < 6);
            c_tag[k]  = TW'($urandom_range(0, 3));
            c_idx[k]  = IW'($urandom_range(0, 1));
            c_data[k] = {$urandom, $urandom};
            c_snp[k]  = {$urandom, $urandom};
            c_msg[k]  = 2'($urandom_range(1, 3));
         end
         snp_vld = '0;
         if ($urandom_range(0, 9) < 3) snp_vld[$urandom_range(0, NC-1)] = 1'b1;
         mem_ack = 1'($urandom_range(0, 1));
         rsp_ack = '0;
         if (mq[m_head].vld && mq[m_head].rdy && $urandom_range(0, 9) < 6)
            rsp_ack[mq[m_head].id] = 1'b1;
         cand.delete();
         for (int s = 0; s < D; s++) if (mq[s].vld && !mq[s].rdy) cand.push_back(s);
         mem_vld = 0;
         mem_data = {$urandom, $urandom};
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_vld = 1;
            mem_ptr = 2'(cand[$urandom_range(0, cand.size()-1)]);
         end
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
